// File: rtl/fifo_read_drain.sv
// fifo_read_drain: drains a FIFO with one-cycle read latency into a two-entry
// skid buffer that feeds a valid/ready stream, and keeps transfer statistics.
module fifo_read_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           word_count,
  output logic [15:0]           checksum,
  output logic                  busy
);

  localparam int SUM_W = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q, occ_d;
  logic [15:0]           word_count_q, word_count_d;
  logic [15:0]           checksum_q, checksum_d;
  logic                  xfer_s;
  logic                  rd_en_s;
  logic [2:0]            credit_s;
  logic [15:0]           data16_s;

  // Read credit, buffer occupancy and statistics next-state.
  always_comb begin
    xfer_s   = (occ_q != 2'd0) & m_ready;
    // The word leaving downstream this cycle frees its slot now, which keeps
    // rd_en high every cycle under full flow without ever overfilling.
    credit_s = {1'b0, occ_q} - {2'b0, xfer_s} + {2'b0, inflight_q};
    rd_en_s  = (state_q == RUN) & enable & ~empty & (credit_s < 3'(BUF_DEPTH));
    occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, xfer_s};
    data16_s = 16'(m_data[SUM_W-1:0]);
    if (xfer_s) begin
      word_count_d = word_count_q + 16'd1;
      checksum_d   = checksum_q + data16_s;
    end else begin
      word_count_d = word_count_q;
      checksum_d   = checksum_q;
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (!enable) state_d = FLUSH;
        else         state_d = RUN;
      end
      FLUSH: begin
        if (enable)                               state_d = RUN;
        else if (!inflight_q && occ_q == 2'd0)    state_d = IDLE;
        else                                      state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, skid buffer and statistics registers.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      word_count_q <= 16'd0;
      checksum_q   <= 16'd0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= rd_en_s;
      occ_q        <= occ_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= data_out;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer_s) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign rd_en      = rd_en_s;
  assign m_data     = buf_q[rd_ptr_q];
  assign m_valid    = (occ_q != 2'd0);
  assign word_count = word_count_q;
  assign checksum   = checksum_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_read_drain.sv
// Scoreboard bench for fifo_read_drain: a FIFO source model issues words on
// rd_en, expected words are queued, and a monitor checks every transfer.
module tb_fifo_read_drain;

  logic        rd_clk, reset, enable, empty, rd_en, m_valid, m_ready, busy;
  logic [15:0] data_out, m_data, word_count, checksum;

  fifo_read_drain #(.DATA_WIDTH(16), .BUF_DEPTH(2)) dut (
    .rd_clk(rd_clk), .reset(reset), .enable(enable), .empty(empty),
    .data_out(data_out), .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .word_count(word_count), .checksum(checksum), .busy(busy)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  int          src_budget = 0;
  int          src_mode   = 0;
  logic        force_empty = 1'b0;
  int          total_xfers = 0;

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FIFO source model: word appears on data_out the cycle after rd_en.
  initial begin
    int          issued = 0;
    logic        pend = 1'b0;
    logic        infl_now;
    logic [15:0] pend_word = 16'd0;
    logic [15:0] seq_ctr = 16'd1;
    logic [15:0] w;
    int          occ_model;
    empty    = 1'b1;
    data_out = 16'd0;
    forever begin
      @(negedge rd_clk);
      infl_now = pend;
      data_out = pend ? pend_word : 16'($urandom);
      pend     = 1'b0;
      #1;
      empty = force_empty | (issued >= src_budget);
      #1;
      if (reset) begin
        issued  = 0;
        seq_ctr = 16'd1;
      end else begin
        occ_model = exp_q.size() - int'(infl_now);
        chk("m_valid_vs_model", m_valid, (occ_model != 0));
        if (infl_now)
          chk("no_write_when_full", (occ_model >= 2) && !(m_valid && m_ready), 0);
        if (rd_en) begin
          chk("rd_en_while_empty", empty, 0);
          case (src_mode)
            0:       begin w = seq_ctr; seq_ctr = seq_ctr + 16'd1; end
            1:       w = 16'($urandom);
            default: w = 16'd1;
          endcase
          exp_q.push_back(w);
          pend_word = w;
          pend      = 1'b1;
          issued++;
        end
      end
    end
  end

  // Monitor: compares each downstream transfer and the registered statistics.
  initial begin
    logic [15:0] exp_cnt = 16'd0;
    logic [15:0] exp_sum = 16'd0;
    logic [15:0] w;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    forever begin
      @(negedge rd_clk);
      #3;
      if (reset) begin
        exp_q.delete();
        exp_cnt = 16'd0;
        exp_sum = 16'd0;
        total_xfers = 0;
        prev_stall = 1'b0;
      end else begin
        chk("word_count", word_count, exp_cnt);
        chk("checksum", checksum, exp_sum);
        if (prev_stall) begin
          chk("stall_valid_held", m_valid, 1);
          chk("stall_data_stable", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_transfer", 1, 0);
          end else begin
            w = exp_q.pop_front();
            chk("m_data_order", m_data, w);
            exp_cnt = exp_cnt + 16'd1;
            exp_sum = exp_sum + w;
            total_xfers++;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  task automatic do_reset();
    @(negedge rd_clk);
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    src_budget = 0; src_mode = 0;
    @(negedge rd_clk);
    reset = 1'b0;
  endtask

  task automatic wait_wc(input logic [15:0] target, input int bound);
    int n = 0;
    while (word_count !== target && n < bound) begin
      @(negedge rd_clk); #4; n++;
    end
    chk("wait_word_count", word_count, target);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge rd_clk); #4; n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    logic rd_log [16];
    logic mv_log [16];
    int   k, cnt;
    logic ok;

    reset = 1'b1; enable = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_checksum", checksum, 0);
    @(negedge rd_clk);
    reset = 1'b0;

    // Full-rate drain of 1..8
    for (int i = 0; i < 16; i++) begin
      @(negedge rd_clk);
      if (i == 0) begin src_budget = 8; enable = 1'b1; m_ready = 1'b1; end
      #4;
      rd_log[i] = rd_en; mv_log[i] = m_valid;
    end
    k = 99; cnt = 0;
    for (int i = 15; i >= 0; i--) if (rd_log[i]) k = i;
    for (int i = 0; i < 16; i++) if (rd_log[i]) cnt++;
    chk("t1_first_rd_cycle", k, 1);
    chk("t1_rd_pulses", cnt, 8);
    ok = (k + 9 < 16) && !mv_log[k+1];
    for (int i = 0; i < 8; i++)
      if (k + 9 < 16) ok = ok && rd_log[k+i] && mv_log[k+2+i];
    chk("t1_sustained_rate", ok, 1);
    chk("t1_word_count", word_count, 16'd8);
    chk("t1_checksum", checksum, 16'h0024);

    // Backpressure: only two reads before the buffer is full
    do_reset();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      if (i == 0) begin src_budget = 8; enable = 1'b1; end
      #4;
      if (rd_en) cnt++;
    end
    chk("t2_rd_pulses", cnt, 2);
    chk("t2_m_valid", m_valid, 1);
    chk("t2_m_data_head", m_data, 16'h0001);
    @(negedge rd_clk); m_ready = 1'b1;
    wait_wc(16'd8, 40);
    chk("t2_checksum", checksum, 16'h0024);

    // FIFO empty for cycles 4-6
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      if (i == 0) begin src_budget = 8; enable = 1'b1; m_ready = 1'b1; end
      force_empty = (i >= 4 && i <= 6);
      #4;
      if (i >= 4 && i <= 6) chk("t3_rd_en_gap", rd_en, 0);
    end
    force_empty = 1'b0;
    wait_wc(16'd8, 40);
    chk("t3_checksum", checksum, 16'h0024);

    // Enable dropped the cycle after a read
    do_reset();
    @(negedge rd_clk); src_budget = 8; enable = 1'b1; m_ready = 1'b1;
    @(negedge rd_clk); #4; chk("t4_rd_en", rd_en, 1);
    @(negedge rd_clk); enable = 1'b0;
    @(negedge rd_clk); #4; chk("t4_flush_busy", busy, 1);
    wait_idle(20);
    chk("t4_word_count", word_count, 16'd1);
    chk("t4_checksum", checksum, 16'h0001);
    chk("t4_m_valid", m_valid, 0);

    // Reset with two words buffered
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge rd_clk);
      if (i == 0) begin src_budget = 20; enable = 1'b1; end
      m_ready = (i < 6);
    end
    #4;
    chk("t5_pre_valid", m_valid, 1);
    @(negedge rd_clk);
    reset = 1'b1;
    #1;
    chk("t5_rst_m_valid", m_valid, 0);
    chk("t5_rst_word_count", word_count, 0);
    chk("t5_rst_checksum", checksum, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rd_en", rd_en, 0);
    do_reset();

    // Randomized traffic
    src_mode = 1; src_budget = 1000000;
    for (int i = 0; i < 3000; i++) begin
      @(negedge rd_clk);
      enable      = ($urandom_range(0, 7) != 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 4) == 0);
    end
    @(negedge rd_clk);
    enable = 1'b0; m_ready = 1'b1; force_empty = 1'b0;
    wait_idle(20);
    chk("t6_scoreboard_drained", exp_q.size(), 0);
    chk("t6_m_valid", m_valid, 0);

    // 65536 transfers of 0x0001 wrap both statistics
    do_reset();
    src_mode = 2; src_budget = 65536; enable = 1'b1; m_ready = 1'b1;
    k = 0;
    while (total_xfers < 65536 && k < 70000) begin
      @(negedge rd_clk); #4; k++;
    end
    chk("t7_total_transfers", total_xfers, 65536);
    @(negedge rd_clk); #4;
    chk("t7_word_count_wrap", word_count, 16'h0000);
    chk("t7_checksum_wrap", checksum, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
